// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: widths, opcode encodings, fetch FSM states and buffer entry layout.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    FS_RESET_WAIT = 2'd0,
    FS_RUN        = 2'd1,
    FS_HALT       = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [6:0] opcode_of(input logic [ILEN-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer for the fetch stage. Head is visible combinationally;
// flush empties the buffer and overrides any push/pop in the same cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

`ifndef SYNTHESIS
  // Credit accounting upstream must make overflow impossible.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(push && full && !pop)) else $error("fetch_fifo overflow");
    end
  end
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC, request credit, stale-response drop counter and run/halt FSM.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect -> sticky fault + halt).
module instruction_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode,
  output logic        fetch_fault
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW = CW + 4;

  fetch_state_e  state_q, state_d;
  logic          fault_q, fault_d;
  logic [31:0]   pc_q;
  logic [CW-1:0] inflight_q;
  logic [DW-1:0] drop_q;

  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          pop;
  logic          credit_ok;
  logic          misaligned;
  logic [31:0]   target_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full_unused;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign target_pc  = redirect_pc;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign misaligned           = 1'b0;
  assign target_pc            = {redirect_pc[31:2], 2'b00};
`endif

  assign credit_ok      = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = (state_q == FS_RUN) && credit_ok && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep       = imem_rsp_valid && (drop_q == '0);
  assign pop            = if_valid && if_ready;

  // Responses return in order, so the oldest live request's PC is pc_q minus one word per
  // request still in flight; no per-request PC storage is needed.
  assign rsp_pc           = pc_q - XLEN'({inflight_q, 2'b00});
  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rsp_data;

  assign if_valid    = !fifo_empty;
  assign if_pc       = head_entry.pc;
  assign if_instr    = head_entry.instr;
  assign if_opcode   = opcode_of(head_entry.instr);
  assign fetch_fault = fault_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep && !redirect_valid),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full_unused)
  );

  // State and fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RESET_WAIT;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Next-state: leave reset wait after one cycle; redirects decide between run and halt.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if (state_q == FS_RESET_WAIT) state_d = FS_RUN;
    if (redirect_valid) begin
      if (misaligned) begin
        state_d = FS_HALT;
        fault_d = 1'b1;
      end else begin
        fault_d = 1'b0;
        if (state_q == FS_HALT) state_d = FS_RUN;
      end
    end
  end

  // PC, in-flight credit and drop counter. On redirect every request still owed by memory
  // (dropped or live, plus one accepted now, minus one answered now) becomes a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else if (redirect_valid) begin
      pc_q       <= target_pc;
      inflight_q <= '0;
      drop_q     <= drop_q + DW'(inflight_q) + DW'(req_fire) - DW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_q <= pc_q + 32'd4;
      inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_keep);
      if (rsp_drop) drop_q <= drop_q - DW'(1);
    end
  end

endmodule
